dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (dat_mem) between the processor core and a host loader/dumper.
//  The core's load/store gets priority; if the core holds the memory too long, the core is stalled.
//  The host moves bursts of consecutive words (program data in, results out).

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core (priority, zero latency)
// and a host burst loader/dumper. A starvation counter forces the host in after STARVE_MAX wins.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int LW         = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [LW-1:0] host_len,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          host_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ARB    = 1'b0,
        HBURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] base_q, base_d;
    logic          we_q, we_d;
    logic          rvalid_q, rvalid_d;
    logic          done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          starved;
    logic          accept;
    logic          wr_en_c;
    logic          ack_c;

    assign starved = (starve_q == SW'(STARVE_MAX));
    assign accept  = (state_q == ARB) && host_req && (!core_req || starved);

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        beat_d     = beat_q;
        len_d      = len_q;
        base_d     = base_q;
        we_d       = we_q;
        rvalid_d   = 1'b0;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        mem_addr   = core_addr;
        mem_din    = core_wdata;
        wr_en_c    = 1'b0;
        core_stall = 1'b0;
        host_gnt   = 1'b0;
        ack_c      = 1'b0;

        case (state_q)
            ARB: begin
                // The core is always served here, even in the cycle the host is accepted.
                if (core_req) begin
                    wr_en_c = core_we;
                end
                if (accept) begin
                    base_d   = host_addr;
                    len_d    = host_len;
                    we_d     = host_we;
                    beat_d   = '0;
                    starve_d = '0;
                    ack_c    = 1'b1;
                    state_d  = HBURST;
                end else if (!host_req) begin
                    starve_d = '0;
                end else if (core_req && !starved) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            HBURST: begin
                core_stall = core_req;
                host_gnt   = 1'b1;
                mem_addr   = base_q + AW'(beat_q);
                mem_din    = host_wdata;
                wr_en_c    = we_q;
                if (!we_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem_dout;
                end
                beat_d = beat_q + 1'b1;
                if (beat_q == len_q) begin
                    state_d = ARB;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB;
            starve_q <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            base_q   <= base_d;
            we_q     <= we_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end

    // Strobes are forced low while reset is held so nothing reaches memory or the host.
    assign mem_wr_en   = wr_en_c & ~reset;
    assign host_ack    = ack_c & ~reset;
    assign core_rdata  = mem_dout;
    assign host_rdata  = rdata_q;
    assign host_rvalid = rvalid_q;
    assign host_done   = done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected beats/read data/done events,
// a negedge monitor pops and compares them; timing-specific checks are made inline.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_req, core_we;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       core_stall;
    logic       host_req, host_we;
    logic [7:0] host_addr;
    logic [3:0] host_len;
    logic [7:0] host_wdata, host_rdata;
    logic       host_ack, host_gnt, host_rvalid, host_done;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic       mem_wr_en;

    logic [7:0] mem [256];

    typedef struct packed {
        logic [7:0] addr;
        logic       we;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_beat[$];
    logic [7:0] exp_rd[$];
    logic       exp_done[$];
    int         n_cmp = 0;
    int         n_err = 0;

    dmem_arbiter #(.AW(8), .DW(8), .LW(4), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_len(host_len), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .host_done(host_done), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event with nothing expected at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        beat_t b;
        logic [7:0] r;
        if (!reset) begin
            if (host_gnt) begin
                if (exp_beat.size() == 0) unexpected("gnt");
                else begin
                    b = exp_beat.pop_front();
                    chk("beat_addr", mem_addr, b.addr);
                    chk("beat_we", mem_wr_en, b.we);
                    if (b.we) chk("beat_din", mem_din, b.data);
                end
            end
            if (host_rvalid) begin
                if (exp_rd.size() == 0) unexpected("rvalid");
                else begin
                    r = exp_rd.pop_front();
                    chk("rdata", host_rdata, r);
                end
            end
            if (host_done) begin
                if (exp_done.size() == 0) unexpected("done");
                else chk("done", host_done, exp_done.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic core_store(input logic [7:0] a, input logic [7:0] d);
        core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d;
        @(negedge clk);
        chk("store_wr_en", mem_wr_en, 1'b1);
        chk("store_stall", core_stall, 1'b0);
        cyc();
        core_req = 1'b0; core_we = 1'b0;
    endtask

    task automatic host_burst(input logic we, input logic [7:0] base, input logic [3:0] len,
                              input logic [7:0] wd [16], input logic [7:0] rd [16]);
        int waited;
        for (int i = 0; i <= int'(len); i++) begin
            exp_beat.push_back('{addr: base + 8'(i), we: we, data: wd[i]});
            if (!we) exp_rd.push_back(rd[i]);
        end
        exp_done.push_back(1'b1);
        host_req = 1'b1; host_we = we; host_addr = base; host_len = len;
        waited = 0;
        @(negedge clk);
        while (!host_ack && waited < 20) begin
            cyc(); waited++; @(negedge clk);
        end
        chk("burst_ack", host_ack, 1'b1);
        cyc();
        host_req = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            host_wdata = wd[i];
            cyc();
        end
        @(negedge clk);
        chk("burst_done_pulse", host_done, 1'b1);
        chk("burst_gnt_end", host_gnt, 1'b0);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] wd [16];
        logic [7:0] rd [16];
        for (int i = 0; i < 16; i++) begin wd[i] = 8'h00; rd[i] = 8'h00; end

        reset = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h42; core_wdata = 8'hEE;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_len = 4'h0; host_wdata = 8'h00;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_ack", host_ack, 1'b0);
        chk("rst_gnt", host_gnt, 1'b0);
        chk("rst_rvalid", host_rvalid, 1'b0);
        chk("rst_done", host_done, 1'b0);
        chk("rst_rdata", host_rdata, 8'h00);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_stall", core_stall, 1'b0);
        cyc();
        reset = 1'b0; core_req = 1'b0; core_we = 1'b0;
        cyc();

        core_store(8'h42, 8'h99);
        core_store(8'hFE, 8'h3C);
        core_store(8'hFF, 8'hC3);
        core_store(8'h00, 8'h5A);

        // Host write burst of four beats with the core idle
        wd[0] = 8'hA0; wd[1] = 8'hA1; wd[2] = 8'hA2; wd[3] = 8'hA3;
        host_burst(1'b1, 8'h10, 4'd3, wd, rd);
        chk("mem10", mem[8'h10], 8'hA0);
        chk("mem11", mem[8'h11], 8'hA1);
        chk("mem12", mem[8'h12], 8'hA2);
        chk("mem13", mem[8'h13], 8'hA3);

        // Host read wrapping past 0xFF
        rd[0] = 8'h3C; rd[1] = 8'hC3; rd[2] = 8'h5A;
        host_burst(1'b0, 8'hFE, 4'd2, wd, rd);

        // Reset during beat 2 of an 8-beat write
        exp_beat.push_back('{addr: 8'h40, we: 1'b1, data: 8'h71});
        exp_beat.push_back('{addr: 8'h41, we: 1'b1, data: 8'h72});
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_len = 4'd7;
        @(negedge clk);
        chk("t1_ack", host_ack, 1'b1);
        cyc();
        host_req = 1'b0; host_wdata = 8'h71;
        cyc();
        host_wdata = 8'h72;
        cyc();
        host_wdata = 8'h73;
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h42; core_wdata = 8'hEE;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t1_rvalid", host_rvalid, 1'b0);
        chk("t1_done", host_done, 1'b0);
        chk("t1_wr_en", mem_wr_en, 1'b0);
        chk("t1_gnt", host_gnt, 1'b0);
        chk("t1_stall", core_stall, 1'b0);
        cyc();
        reset = 1'b0; core_req = 1'b0; core_we = 1'b0;
        @(negedge clk);
        chk("t1_arb_gnt", host_gnt, 1'b0);
        cyc();
        @(negedge clk);
        chk("t1_no_done", host_done, 1'b0);
        cyc();
        chk("t1_mem40", mem[8'h40], 8'h71);
        chk("t1_mem41", mem[8'h41], 8'h72);
        chk("t1_mem42", mem[8'h42], 8'h99);

        // Continuous core traffic against a host read: forced entry after 4 wins
        exp_beat.push_back('{addr: 8'h10, we: 1'b0, data: 8'h00});
        exp_beat.push_back('{addr: 8'h11, we: 1'b0, data: 8'h00});
        exp_rd.push_back(8'hA0); exp_rd.push_back(8'hA1);
        exp_done.push_back(1'b1);
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h30;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_len = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_ack", host_ack, (i == 4));
            chk("t4_stall_arb", core_stall, 1'b0);
            chk("t4_core_addr", mem_addr, 8'h30);
            if (i < 4) cyc();
        end
        cyc();
        host_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_stall_burst", core_stall, 1'b1);
            cyc();
        end
        @(negedge clk);
        chk("t4_done", host_done, 1'b1);
        chk("t4_stall_after", core_stall, 1'b0);
        cyc();
        core_req = 1'b0;
        cyc();

        // Same-cycle core store and host read of 0x20: core first, host sees the stored value
        exp_beat.push_back('{addr: 8'h20, we: 1'b0, data: 8'h00});
        exp_rd.push_back(8'h55);
        exp_done.push_back(1'b1);
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h55;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20; host_len = 4'd0;
        @(negedge clk);
        chk("t5_ack0", host_ack, 1'b0);
        chk("t5_wr_en", mem_wr_en, 1'b1);
        chk("t5_addr", mem_addr, 8'h20);
        chk("t5_stall", core_stall, 1'b0);
        cyc();
        core_req = 1'b0; core_we = 1'b0;
        @(negedge clk);
        chk("t5_ack1", host_ack, 1'b1);
        cyc();
        host_req = 1'b0;
        cyc();
        @(negedge clk);
        chk("t5_done", host_done, 1'b1);
        cyc();

        // Dropping host_req clears the starvation count
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h31;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20; host_len = 4'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6_pre_ack", host_ack, 1'b0);
            cyc();
        end
        host_req = 1'b0;
        @(negedge clk);
        chk("t6_drop_ack", host_ack, 1'b0);
        cyc();
        exp_beat.push_back('{addr: 8'h20, we: 1'b0, data: 8'h00});
        exp_rd.push_back(8'h55);
        exp_done.push_back(1'b1);
        host_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_ack", host_ack, (i == 4));
            if (i < 4) cyc();
        end
        cyc();
        host_req = 1'b0;
        @(negedge clk);
        chk("t6_stall", core_stall, 1'b1);
        cyc();
        @(negedge clk);
        chk("t6_done", host_done, 1'b1);
        cyc();
        core_req = 1'b0;
        cyc(); cyc(); cyc();

        chk("left_beats", exp_beat.size(), 0);
        chk("left_rdata", exp_rd.size(), 0);
        chk("left_done", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
